// File: rtl/ntt_pkg.sv
// Shared types and schedule tables for the sequential 4-point NTT controller.
package ntt_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    COMP  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned NWORDS = 4;
  localparam int unsigned IDXW   = 2;

  typedef logic [IDXW-1:0] idx_t;

  // Per-op operand indices: a0 is written back to RD_X, a1 to RD_Y.
  localparam idx_t OP_RD_X   [NWORDS] = '{2'd0, 2'd1, 2'd0, 2'd2};
  localparam idx_t OP_RD_Y   [NWORDS] = '{2'd2, 2'd3, 2'd1, 2'd3};
  localparam logic OP_TW_SEL [NWORDS] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Bit-reversed bank order for natural-order output.
  localparam idx_t OUT_IDX   [NWORDS] = '{2'd0, 2'd2, 2'd1, 2'd3};

endpackage

// File: rtl/mod_butterfly.sv
// Combinational modular butterfly: a0 = x + w*y, a1 = x - w*y (mod Q).
module mod_butterfly #(
  parameter int unsigned    BITS = 32,
  parameter logic [BITS-1:0] Q   = BITS'(5)
) (
  input  logic [BITS-1:0] x,
  input  logic [BITS-1:0] y,
  input  logic [BITS-1:0] w,
  output logic [BITS-1:0] a0,
  output logic [BITS-1:0] a1
);

  localparam int unsigned PW = 2 * BITS;

  logic [PW-1:0]   prod;
  logic [BITS-1:0] p;
  logic [BITS:0]   sum;
  logic [BITS:0]   dif;
  logic [BITS:0]   q_ext;

  // Operands are already < Q, so one conditional subtract finishes each reduction.
  always_comb begin
    q_ext = {1'b0, Q};
    prod  = PW'(w) * PW'(y);
    p     = BITS'(prod % PW'(Q));
    sum   = {1'b0, x} + {1'b0, p};
    dif   = {1'b0, x} + q_ext - {1'b0, p};
    a0    = (sum >= q_ext) ? BITS'(sum - q_ext) : BITS'(sum);
    a1    = (dif >= q_ext) ? BITS'(dif - q_ext) : BITS'(dif);
  end

endmodule

// File: rtl/ntt4_seq_ctrl.sv
// 4-point NTT sequencer sharing one mod_butterfly over four in-place ops.
// Optional NTT_XFORM_CNT_EN adds a 16-bit completed-transform counter output.
module ntt4_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned    BITS = 32,
  parameter logic [BITS-1:0] Q   = BITS'(5)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic [BITS-1:0] w0,
  input  logic [BITS-1:0] w1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            busy,
  output logic            done
`ifdef NTT_XFORM_CNT_EN
  ,
  output logic [15:0]     xform_cnt
`endif
);

  state_e          state_q, state_d;
  idx_t            ld_cnt_q, ld_cnt_d;
  idx_t            op_cnt_q, op_cnt_d;
  idx_t            dr_cnt_q, dr_cnt_d;
  logic [BITS-1:0] r_q [NWORDS];
  logic [BITS-1:0] r_d [NWORDS];
  logic [BITS-1:0] w0_q, w0_d;
  logic [BITS-1:0] w1_q, w1_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic            busy_q, busy_d;

  logic [BITS-1:0] bf_x, bf_y, bf_w, bf_a0, bf_a1;
  logic            in_hs, out_hs;

  assign bf_x = r_q[OP_RD_X[op_cnt_q]];
  assign bf_y = r_q[OP_RD_Y[op_cnt_q]];
  assign bf_w = OP_TW_SEL[op_cnt_q] ? w1_q : w0_q;

  mod_butterfly #(.BITS(BITS), .Q(Q)) u_bf (
    .x  (bf_x),
    .y  (bf_y),
    .w  (bf_w),
    .a0 (bf_a0),
    .a1 (bf_a1)
  );

  assign in_hs  = in_ready_q && in_valid;
  assign out_hs = out_valid_q && out_ready;

  // Next-state, bank update and next registered outputs.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    op_cnt_d = op_cnt_q;
    dr_cnt_d = dr_cnt_q;
    r_d      = r_q;
    w0_d     = w0_q;
    w1_d     = w1_q;

    case (state_q)
      LOAD: begin
        if (in_hs) begin
          r_d[ld_cnt_q] = in_data % Q;
          if (ld_cnt_q == 2'd0) begin
            w0_d = w0 % Q;
            w1_d = w1 % Q;
          end
          ld_cnt_d = ld_cnt_q + 2'd1;
          if (ld_cnt_q == 2'd3) begin
            ld_cnt_d = 2'd0;
            state_d  = COMP;
          end
        end
      end
      COMP: begin
        r_d[OP_RD_X[op_cnt_q]] = bf_a0;
        r_d[OP_RD_Y[op_cnt_q]] = bf_a1;
        op_cnt_d = op_cnt_q + 2'd1;
        if (op_cnt_q == 2'd3) begin
          op_cnt_d = 2'd0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          dr_cnt_d = dr_cnt_q + 2'd1;
          if (dr_cnt_q == 2'd3) begin
            dr_cnt_d = 2'd0;
            state_d  = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != LOAD);
    out_data_d  = out_valid_d ? r_d[OUT_IDX[dr_cnt_d]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      ld_cnt_q    <= '0;
      op_cnt_q    <= '0;
      dr_cnt_q    <= '0;
      r_q         <= '{default: '0};
      w0_q        <= '0;
      w1_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      op_cnt_q    <= op_cnt_d;
      dr_cnt_q    <= dr_cnt_d;
      r_q         <= r_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  // Pulse coincides with the b3 handshake itself, so it follows out_ready directly.
  assign done      = out_hs && (dr_cnt_q == 2'd3);

`ifdef NTT_XFORM_CNT_EN
  logic [15:0] xform_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xform_cnt_q <= '0;
    end else if (done) begin
      xform_cnt_q <= xform_cnt_q + 16'd1;
    end
  end

  assign xform_cnt = xform_cnt_q;
`endif

endmodule

// File: tb/tb_ntt4_seq_ctrl.sv
// Directed self-checking bench for ntt4_seq_ctrl (BITS=32, Q=5).
module tb_ntt4_seq_ctrl;

  typedef logic [31:0] vec_t [4];

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] w0;
  logic [31:0] w1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
`ifdef NTT_XFORM_CNT_EN
  logic [15:0] xform_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ntt4_seq_ctrl #(.BITS(32), .Q(32'd5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w0        (w0),
    .w1        (w1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef NTT_XFORM_CNT_EN
    ,
    .xform_cnt (xform_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load4(input vec_t xs, input logic [31:0] w0a, w1a, w0b, w1b);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = xs[i];
      w0       = (i == 0) ? w0a : w0b;
      w1       = (i == 0) ? w1a : w1b;
      @(posedge clk);
      #1;
    end
  endtask

  // Loads xs, then drains four results, optionally stalling before result stall_at.
  task automatic run_xform(input string tag, input vec_t xs,
                           input logic [31:0] w0a, w1a, w0b, w1b,
                           input vec_t exp, input int stall_at);
    int cyc, first, busy_n, done_n, k;
    bit stalled;
    cyc = 0; first = -1; busy_n = 0; done_n = 0; k = 0; stalled = 0;
    out_ready = 1'b1;
    load4(xs, w0a, w1a, w0b, w1b);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFF0;
    while (k < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (out_valid && first < 0) first = cyc;
      if (!out_valid) check({tag, "_idle_data"}, out_data, 32'd0);
      if (out_valid && k == stall_at && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          cyc++;
          if (busy) busy_n++;
          if (done) done_n++;
          check({tag, "_bp_data"}, out_data, exp[k]);
          check({tag, "_bp_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
      end
      if (out_valid && out_ready) begin
        check({tag, "_data"}, out_data, exp[k]);
        check({tag, "_done"}, {31'd0, done}, (k == 3) ? 32'd1 : 32'd0);
        if (done) done_n++;
        if (k == 3) in_valid = 1'b0;
        k++;
      end
    end
    check({tag, "_outputs_seen"}, 32'(k), 32'd4);
    @(negedge clk);
    check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), (stall_at >= 0) ? 32'd18 : 32'd8);
    check({tag, "_latency"}, 32'(first), 32'd5);
  endtask

  initial begin
    vec_t x1234, x6789, x0, e0432, e0, e2223, xr;
    x1234 = '{32'd1, 32'd2, 32'd3, 32'd4};
    x6789 = '{32'd6, 32'd7, 32'd8, 32'd9};
    x0    = '{32'd0, 32'd0, 32'd0, 32'd0};
    xr    = '{32'd3, 32'd1, 32'd4, 32'd1};
    e0432 = '{32'd0, 32'd4, 32'd3, 32'd2};
    e0    = '{32'd0, 32'd0, 32'd0, 32'd0};
    e2223 = '{32'd2, 32'd2, 32'd2, 32'd3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; w0 = '0; w1 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef NTT_XFORM_CNT_EN
    check("rst_xform_cnt", 32'(xform_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_xform("basic", x1234, 32'd1, 32'd2, 32'd1, 32'd2, e0432, -1);
    run_xform("zeros", x0, 32'd3, 32'd4, 32'd3, 32'd4, e0, -1);
    run_xform("reduce_bp", x6789, 32'd6, 32'd7, 32'd6, 32'd7, e0432, 1);

    // Abort a transform during op2 of COMP.
    @(posedge clk);
    #1;
    load4(xr, 32'd1, 32'd2, 32'd1, 32'd2);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_r0", dut.r_q[0], 32'd0);
    check("abort_r1", dut.r_q[1], 32'd0);
    check("abort_r2", dut.r_q[2], 32'd0);
    check("abort_r3", dut.r_q[3], 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_output", {31'd0, out_valid}, 32'd0);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end

    run_xform("tw_change", x1234, 32'd2, 32'd3, 32'd4, 32'd4, e2223, -1);
    run_xform("b2b", x1234, 32'd1, 32'd2, 32'd1, 32'd2, e0432, -1);
`ifdef NTT_XFORM_CNT_EN
    check("xform_cnt", 32'(xform_cnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt4_seq_ctrl.md
Name: ntt4_seq_ctrl

Overview:
Sequencer that time-multiplexes one modular butterfly unit to compute a 4-point NTT over 4 cycles, replacing the 4-butterfly combinational array. Coefficients stream in one per cycle via valid/ready into a 4-word register bank. Two stages of two butterflies each run in place, then results stream out in natural order. It sits between the coefficient source and the pointwise-multiply stage of the polynomial multiplier.

Parameters:
BITS, 32, coefficient/twiddle word width
Q, 5, prime modulus; must satisfy 2 <= Q < 2**BITS

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data
in_data  input  BITS  coefficient, order x0..x3
w0  input  BITS  stage-1 and stage-2 upper twiddle, sampled on first-coefficient handshake
w1  input  BITS  stage-2 lower twiddle, sampled alongside w0
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
out_data  output  BITS  result, order b0..b3
busy  output  1  high in COMP and DRAIN
done  output  1  one-cycle pulse on handshake of b3

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=LOAD, all counters=0, bank r0..r3=0, latched twiddles=0, in_ready=1, out_valid=0, out_data=0, busy=0, done=0. Reset asserted in any state aborts the transform with no output and no done pulse.
- Butterfly (x,y,w): p=(w*y) mod Q, with a 2*BITS-wide product. a0=(x+p) mod Q. a1=(x-p+Q) mod Q. Results are always < Q.
- LOAD: in_ready=1.
  - Each handshake writes (in_data mod Q) to r[ld_cnt] and increments ld_cnt.
  - When ld_cnt=0, w0 and w1 are latched, each reduced mod Q.
  - After the 4th handshake, go to COMP and clear ld_cnt.
- COMP: in_ready=0. One op per cycle; op_cnt runs 0..3 and each op writes back on the same edge.
  - op0: (r0,r2,w0) -> r0=a0, r2=a1
  - op1: (r1,r3,w0) -> r1=a0, r3=a1
  - op2: (r0,r1,w0) -> r0=a0, r1=a1
  - op3: (r2,r3,w1) -> r2=a0, r3=a1
  - After op3, go to DRAIN.
- DRAIN: out_valid=1. out_data = r[{0,2,1,3}[dr_cnt]], so the output order b0..b3 is r0, r2, r1, r3.
  - dr_cnt advances on out_valid && out_ready.
  - out_data stays stable while out_ready=0.
  - On the 4th handshake: done=1 for that cycle only, then return to LOAD.
  - in_ready is asserted the cycle after the 4th handshake.
- Latency: the last input handshake happens at cycle T. COMP runs T+1..T+4 and out_valid first rises at T+5. Minimum period is 12 cycles per transform.
- in_valid while not in LOAD is ignored. w0/w1 changes after sampling have no effect.
- out_data=0 whenever out_valid=0.

Optional Feature:
NTT_XFORM_CNT_EN: when defined, adds output port xform_cnt [15:0].
- Reset value is 0. It increments on each done pulse and wraps from 0xFFFF to 0.
- When undefined, the port and the counter are absent and all other behaviour is identical.

Decomposition:
- Package ntt_pkg holds:
  - state enum {LOAD, COMP, DRAIN}
  - op schedule constants: read/write indices and twiddle select per op
  - output bit-reverse index table {0,2,1,3}
- One sub-module, mod_butterfly: combinational, with ports x, y, w -> a0, a1. It is instantiated once and shared across all four ops.

Test Plan:
- Q=5, w0=1, w1=2, in 1,2,3,4 back-to-back, out_ready=1 -> out 0,4,3,2; done pulses once with b3; out_valid first rises 5 cycles after the 4th input handshake.
- Q=5, inputs all 0, any twiddles -> out 0,0,0,0; busy is high for exactly 8 cycles.
- Reduction: Q=5, w0=6, w1=7, in 6,7,8,9 (≡1,2,3,4) -> out 0,4,3,2.
- Backpressure: out_ready held low 10 cycles during b1 -> out_data=4 stable, in_ready=0 throughout, no extra done.
- Reset mid-COMP at op2 -> next cycle in_ready=1, out_valid=0, r0..r3=0. A fresh transform then yields correct results.
- Back-to-back transforms with twiddles changed mid-load -> the second transform uses the twiddles sampled at its first handshake. With NTT_XFORM_CNT_EN defined, xform_cnt=2 afterwards.
